// File: rtl/ones_to_frame.sv
// Serialises a requested ones-count into a FRAME_LEN-bit frame whose ones are
// spread evenly by an accumulator, and publishes each finished frame as a word.
module ones_to_frame #(
  parameter int FRAME_LEN   = 16,
  parameter int COUNT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [COUNT_WIDTH-1:0] in_count,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   dout,
  output logic                   dout_valid,
  output logic                   frame_start,
  output logic [FRAME_LEN-1:0]   frame_word,
  output logic                   word_valid,
  output logic                   sat_err,
  output logic                   dbg_state
);

  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int ACC_W = $clog2(2 * FRAME_LEN);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [COUNT_WIDTH-1:0] FL_C     = COUNT_WIDTH'(FRAME_LEN);
  localparam logic [ACC_W-1:0]       FL_A     = ACC_W'(FRAME_LEN);

  // Handshake: a count transfers on a rising edge where in_valid and in_ready
  // are both 1; in_ready is registered and only high in IDLE or on the last bit.
  logic [0:0]             state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d, idx_inc;
  logic [ACC_W-1:0]       acc_q, acc_d, step_acc, sum, acc_next;
  logic [COUNT_WIDTH-1:0] n_q, n_d, sat_n, step_n;
  logic [FRAME_LEN-1:0]   build_q, build_d, word_q, word_d;
  logic                   in_ready_q, in_ready_d;
  logic                   dout_q, dout_d, dv_q, dv_d, fs_q, fs_d;
  logic                   wv_q, wv_d, sat_q, sat_d;
  logic                   accept, bit_v, last_bit;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    n_d      = n_q;
    build_d  = build_q;
    word_d   = word_q;
    dout_d   = 1'b0;
    dv_d     = 1'b0;
    fs_d     = 1'b0;
    wv_d     = 1'b0;
    sat_d    = 1'b0;

    accept   = in_valid && in_ready_q;
    last_bit = (state_q == S_RUN) && (idx_q == LAST_IDX);
    idx_inc  = idx_q + IDX_W'(1);
    sat_n    = (in_count > FL_C) ? FL_C : in_count;
    // A new frame restarts the accumulator from zero with the new count.
    step_n   = accept ? sat_n : n_q;
    step_acc = accept ? '0 : acc_q;
    sum      = step_acc + ACC_W'(step_n);
    bit_v    = (sum >= FL_A);
    acc_next = bit_v ? (sum - FL_A) : sum;

    if (last_bit) begin
      word_d  = build_q;
      wv_d    = 1'b1;
      state_d = S_IDLE;
      idx_d   = '0;
      acc_d   = '0;
    end

    if (accept) begin
      state_d    = S_RUN;
      idx_d      = '0;
      n_d        = sat_n;
      acc_d      = acc_next;
      build_d    = '0;
      build_d[0] = bit_v;
      dout_d     = bit_v;
      dv_d       = 1'b1;
      fs_d       = 1'b1;
      sat_d      = (in_count > FL_C);
    end else if ((state_q == S_RUN) && !last_bit) begin
      idx_d            = idx_inc;
      acc_d            = acc_next;
      build_d[idx_inc] = bit_v;
      dout_d           = bit_v;
      dv_d             = 1'b1;
    end

    in_ready_d = (state_d == S_IDLE) || (idx_d == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      acc_q      <= '0;
      n_q        <= '0;
      build_q    <= '0;
      word_q     <= '0;
      in_ready_q <= 1'b0;
      dout_q     <= 1'b0;
      dv_q       <= 1'b0;
      fs_q       <= 1'b0;
      wv_q       <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      n_q        <= n_d;
      build_q    <= build_d;
      word_q     <= word_d;
      in_ready_q <= in_ready_d;
      dout_q     <= dout_d;
      dv_q       <= dv_d;
      fs_q       <= fs_d;
      wv_q       <= wv_d;
      sat_q      <= sat_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign dout        = dout_q;
  assign dout_valid  = dv_q;
  assign frame_start = fs_q;
  assign frame_word  = word_q;
  assign word_valid  = wv_q;
  assign sat_err     = sat_q;
  assign dbg_state   = state_q[0];

endmodule

// File: tb/tb_ones_to_frame.sv
// Directed and randomised checks of ones_to_frame at FRAME_LEN=16.
module tb_ones_to_frame;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  in_count;
  logic        in_valid;
  logic        in_ready;
  logic        dout;
  logic        dout_valid;
  logic        frame_start;
  logic [15:0] frame_word;
  logic        word_valid;
  logic        sat_err;
  logic        dbg_state;

  int total = 0;
  int bad   = 0;
  logic [4:0] exp_q[$];

  ones_to_frame #(.FRAME_LEN(16), .COUNT_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .in_count(in_count), .in_valid(in_valid),
    .in_ready(in_ready), .dout(dout), .dout_valid(dout_valid),
    .frame_start(frame_start), .frame_word(frame_word),
    .word_valid(word_valid), .sat_err(sat_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (in_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s wait_ready: in_ready=%b after %0d cycles, want 1", name, in_ready, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; in_count = '0;
    tick(); tick();
    total++;
    if ({dout, dout_valid, frame_start, word_valid, sat_err, in_ready} !== 6'b0 ||
        frame_word !== 16'h0) begin
      bad++;
      $display("FAIL reset_outputs: dout=%b dv=%b fs=%b wv=%b sat=%b rdy=%b word=%h, want all 0",
               dout, dout_valid, frame_start, word_valid, sat_err, in_ready, frame_word);
    end
    reset = 1'b1;
    tick();
    total++;
    if (in_ready !== 1'b1 || dout_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: rdy=%b dv=%b, want rdy=1 dv=0", in_ready, dout_valid);
    end
  endtask

  task automatic test_frame(input string name, input logic [4:0] cnt,
                            input logic [15:0] w, input logic s);
    wait_ready(name);
    in_count = cnt; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) tick();
      total++;
      if (dout !== w[i] || dout_valid !== 1'b1 || frame_start !== logic'(i == 0) ||
          in_ready !== logic'(i == 15)) begin
        bad++;
        $display("FAIL %s bit%0d: dout=%b dv=%b fs=%b rdy=%b, want dout=%b dv=1 fs=%b rdy=%b",
                 name, i, dout, dout_valid, frame_start, in_ready, w[i], i == 0, i == 15);
      end
      total++;
      if (sat_err !== ((i == 0) ? s : 1'b0)) begin
        bad++;
        $display("FAIL %s sat%0d: sat_err=%b want %b", name, i, sat_err, (i == 0) ? s : 1'b0);
      end
    end
    tick();
    total++;
    if (dout_valid !== 1'b0 || dout !== 1'b0 || word_valid !== 1'b1 || frame_word !== w) begin
      bad++;
      $display("FAIL %s end: dv=%b dout=%b wv=%b word=%h, want dv=0 dout=0 wv=1 word=%h",
               name, dout_valid, dout, word_valid, frame_word, w);
    end
    tick();
    total++;
    if (word_valid !== 1'b0 || frame_word !== w || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s hold: wv=%b word=%h rdy=%b, want wv=0 word=%h rdy=1",
               name, word_valid, frame_word, in_ready, w);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_bits = {16'hFFFF, 16'h9248};
    wait_ready("b2b");
    in_count = 5'd5; in_valid = 1'b1;
    tick();
    in_count = 5'd16;
    for (int c = 0; c < 32; c++) begin
      if (c > 0) tick();
      if (c == 16) in_valid = 1'b0;
      total++;
      if (dout_valid !== 1'b1 || dout !== exp_bits[c] || frame_start !== logic'(c % 16 == 0) ||
          in_ready !== logic'(c % 16 == 15)) begin
        bad++;
        $display("FAIL b2b cyc%0d: dv=%b dout=%b fs=%b rdy=%b, want dv=1 dout=%b fs=%b rdy=%b",
                 c, dout_valid, dout, frame_start, in_ready, exp_bits[c], c % 16 == 0, c % 16 == 15);
      end
      if (c == 16) begin
        total++;
        if (word_valid !== 1'b1 || frame_word !== 16'h9248) begin
          bad++;
          $display("FAIL b2b word1: wv=%b word=%h, want wv=1 word=9248", word_valid, frame_word);
        end
      end
    end
    tick();
    total++;
    if (dout_valid !== 1'b0 || word_valid !== 1'b1 || frame_word !== 16'hFFFF) begin
      bad++;
      $display("FAIL b2b word2: dv=%b wv=%b word=%h, want dv=0 wv=1 word=ffff",
               dout_valid, word_valid, frame_word);
    end
  endtask

  task automatic test_mid_reset();
    wait_ready("mid_reset");
    in_count = 5'd8; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i <= 7; i++) tick();
    reset = 1'b0;
    tick();
    total++;
    if ({dout, dout_valid, frame_start, word_valid, sat_err, in_ready} !== 6'b0 ||
        frame_word !== 16'h0) begin
      bad++;
      $display("FAIL mid_reset_zero: dout=%b dv=%b fs=%b wv=%b sat=%b rdy=%b word=%h, want all 0",
               dout, dout_valid, frame_start, word_valid, sat_err, in_ready, frame_word);
    end
    reset = 1'b1;
    tick();
    total++;
    if (in_ready !== 1'b1 || word_valid !== 1'b0 || dout_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_release: rdy=%b wv=%b dv=%b, want rdy=1 wv=0 dv=0",
               in_ready, word_valid, dout_valid);
    end
  endtask

  task automatic test_random();
    logic [4:0] cnt;
    logic [4:0] exp_n;
    int drain = 0;
    for (int c = 0; c < 900; c++) begin
      in_valid = ($urandom_range(0, 3) == 0);
      in_count = 5'($urandom_range(0, 31));
      cnt = in_count;
      if (in_valid && in_ready) exp_q.push_back((cnt > 5'd16) ? 5'd16 : cnt);
      tick();
      if (word_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rand_unexpected_word: word=%h with empty queue", frame_word);
        end else begin
          exp_n = exp_q.pop_front();
          if (5'($countones(frame_word)) !== exp_n) begin
            bad++;
            $display("FAIL rand_popcount: word=%h ones=%0d, want %0d",
                     frame_word, $countones(frame_word), exp_n);
          end
        end
      end
    end
    in_valid = 1'b0;
    while (exp_q.size() > 0 && drain < 40) begin
      tick();
      drain++;
      if (word_valid) begin
        total++;
        exp_n = exp_q.pop_front();
        if (5'($countones(frame_word)) !== exp_n) begin
          bad++;
          $display("FAIL rand_popcount: word=%h ones=%0d, want %0d",
                   frame_word, $countones(frame_word), exp_n);
        end
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL rand_drain: %0d frames missing, want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_frame("n0", 5'd0, 16'h0000, 1'b0);
    test_frame("n16", 5'd16, 16'hFFFF, 1'b0);
    test_frame("n8", 5'd8, 16'hAAAA, 1'b0);
    test_frame("n5", 5'd5, 16'h9248, 1'b0);
    test_frame("sat20", 5'd20, 16'hFFFF, 1'b1);
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
